// File: rtl/agc_core_if.sv
// agc_core_if: control, write-line and timing-output bundle of the AGC timing/restart core.
`default_nettype none

interface agc_core_if;
  logic STRT1, STRT2, ALGA, MSTP, SBY;
  logic WL01_n, WL02_n, WL03_n, WL04_n, WL05_n, WL06_n, WL07_n, WL08_n;
  logic WL09_n, WL10_n, WL11_n, WL12_n, WL13_n, WL14_n, WL15_n, WL16_n;
  // Control inputs carried through the AGC port list with no effect in this revision
  logic C24A, C44P, WL15, WL16, XT0_n, YT0_n, XB7_n, YB0_n;
  logic FETCH0, INKL, MONWBK, SHIFT, RADRZ;
  logic T01_n, T02_n, T03_n, T04_n, T05_n, T06_n, T07_n, T08_n;
  logic T09_n, T10_n, T11_n, T12_n;
  logic GOJAM, RESTRT;
  logic [15:0] WLREG;
  logic [11:0] FS;

  modport master (
    output STRT1, STRT2, ALGA, MSTP, SBY,
    output WL01_n, WL02_n, WL03_n, WL04_n, WL05_n, WL06_n, WL07_n, WL08_n,
    output WL09_n, WL10_n, WL11_n, WL12_n, WL13_n, WL14_n, WL15_n, WL16_n,
    output C24A, C44P, WL15, WL16, XT0_n, YT0_n, XB7_n, YB0_n,
    output FETCH0, INKL, MONWBK, SHIFT, RADRZ,
    input  T01_n, T02_n, T03_n, T04_n, T05_n, T06_n, T07_n, T08_n,
    input  T09_n, T10_n, T11_n, T12_n,
    input  GOJAM, RESTRT, WLREG, FS
  );

  modport slave (
    input  STRT1, STRT2, ALGA, MSTP, SBY,
    input  WL01_n, WL02_n, WL03_n, WL04_n, WL05_n, WL06_n, WL07_n, WL08_n,
    input  WL09_n, WL10_n, WL11_n, WL12_n, WL13_n, WL14_n, WL15_n, WL16_n,
    input  C24A, C44P, WL15, WL16, XT0_n, YT0_n, XB7_n, YB0_n,
    input  FETCH0, INKL, MONWBK, SHIFT, RADRZ,
    output T01_n, T02_n, T03_n, T04_n, T05_n, T06_n, T07_n, T08_n,
    output T09_n, T10_n, T11_n, T12_n,
    output GOJAM, RESTRT, WLREG, FS
  );
endinterface

`default_nettype wire

// File: rtl/agc_core.sv
// agc_core: 12-phase time-pulse generator, GOJAM restart sequencer, RESTRT flag, WL capture, MCT scaler.
// Optional standby (SBY freezes time pulses) is enabled by defining AGC_STANDBY_EN.
`default_nettype none

module agc_core (
  input  wire         CLOCK,
  input  wire         SIM_RST_n,
  agc_core_if.slave   bus
);

  typedef enum logic [3:0] {
    T01 = 4'd1,  T02 = 4'd2,  T03 = 4'd3,  T04 = 4'd4,
    T05 = 4'd5,  T06 = 4'd6,  T07 = 4'd7,  T08 = 4'd8,
    T09 = 4'd9,  T10 = 4'd10, T11 = 4'd11, T12 = 4'd12
  } tp_t;

  tp_t         tp;
  logic        gojam;
  logic        restrt;
  logic        stby;
  logic [15:0] wlreg;
  logic [11:0] fs;
  logic [3:0]  ps;

  logic        rq;
  logic        sby_req;
  logic [15:0] wl_n;
  tp_t         tp_next;
  logic [11:0] tpulse_n;

  assign rq   = bus.STRT1 | bus.STRT2 | bus.ALGA;
  assign wl_n = {bus.WL16_n, bus.WL15_n, bus.WL14_n, bus.WL13_n,
                 bus.WL12_n, bus.WL11_n, bus.WL10_n, bus.WL09_n,
                 bus.WL08_n, bus.WL07_n, bus.WL06_n, bus.WL05_n,
                 bus.WL04_n, bus.WL03_n, bus.WL02_n, bus.WL01_n};
  assign tp_next = (tp == T12) ? T01 : tp_t'(tp + 4'd1);

`ifdef AGC_STANDBY_EN
  assign sby_req = bus.SBY;
`else
  assign sby_req = 1'b0;
`endif

  // GOJAM ends on the 12->1 wrap, i.e. the 12th edge after the last request sample.
  always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      tp     <= T01;
      gojam  <= 1'b1;
      restrt <= 1'b1;
      stby   <= 1'b0;
      wlreg  <= 16'h0000;
      fs     <= 12'd0;
      ps     <= 4'd0;
    end else begin
      if (ps == 4'd11) begin
        ps <= 4'd0;
        fs <= fs + 12'd1;
      end else begin
        ps <= ps + 4'd1;
      end

      if (rq) begin
        tp     <= T01;
        gojam  <= 1'b1;
        restrt <= 1'b1;
        stby   <= 1'b0;
      end else if (gojam) begin
        tp     <= tp_next;
        restrt <= 1'b1;
        stby   <= 1'b0;
        if (tp == T12)
          gojam <= 1'b0;
      end else if (sby_req) begin
        stby <= 1'b1;
      end else begin
        stby <= 1'b0;
        if (tp == T08) begin
          wlreg <= ~wl_n;
          if (!bus.WL13_n && !bus.WL14_n)
            restrt <= 1'b0;
        end
        if (!(bus.MSTP && tp == T12))
          tp <= tp_next;
      end
    end
  end

  // Decode from registered state only; standby blanks every pulse.
  always_comb begin
    tpulse_n = '1;
    for (int i = 0; i < 12; i++)
      if (!stby && tp == tp_t'(i + 1))
        tpulse_n[i] = 1'b0;
  end

  assign bus.T01_n  = tpulse_n[0];
  assign bus.T02_n  = tpulse_n[1];
  assign bus.T03_n  = tpulse_n[2];
  assign bus.T04_n  = tpulse_n[3];
  assign bus.T05_n  = tpulse_n[4];
  assign bus.T06_n  = tpulse_n[5];
  assign bus.T07_n  = tpulse_n[6];
  assign bus.T08_n  = tpulse_n[7];
  assign bus.T09_n  = tpulse_n[8];
  assign bus.T10_n  = tpulse_n[9];
  assign bus.T11_n  = tpulse_n[10];
  assign bus.T12_n  = tpulse_n[11];
  assign bus.GOJAM  = gojam;
  assign bus.RESTRT = restrt;
  assign bus.WLREG  = wlreg;
  assign bus.FS     = fs;

  logic unused_inputs;
  assign unused_inputs = ^{bus.C24A, bus.C44P, bus.WL15, bus.WL16, bus.XT0_n, bus.YT0_n,
                           bus.XB7_n, bus.YB0_n, bus.FETCH0, bus.INKL, bus.MONWBK,
                           bus.SHIFT, bus.RADRZ, bus.SBY};

endmodule

`default_nettype wire

// File: tb/tb_agc_core.sv
// tb_agc_core: directed scenarios plus randomized traffic against a cycle-level behavioural model.
`default_nettype none

module tb_agc_core;

  logic CLOCK = 1'b0;
  logic SIM_RST_n;
  agc_core_if bus ();

  agc_core dut (.CLOCK(CLOCK), .SIM_RST_n(SIM_RST_n), .bus(bus));

  always #10 CLOCK = ~CLOCK;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: time-pulse phase, edges since the last request sample, edges since reset.
  int          m_tp;
  int          m_low;
  int          m_edges;
  bit          m_stby;
  bit          m_restrt;
  logic [15:0] m_wlreg;
  logic [15:0] wl_n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_wl(input logic [15:0] v);
    wl_n = v;
    {bus.WL16_n, bus.WL15_n, bus.WL14_n, bus.WL13_n, bus.WL12_n, bus.WL11_n,
     bus.WL10_n, bus.WL09_n, bus.WL08_n, bus.WL07_n, bus.WL06_n, bus.WL05_n,
     bus.WL04_n, bus.WL03_n, bus.WL02_n, bus.WL01_n} = v;
  endtask

  task automatic model_reset();
    m_tp = 1; m_low = 0; m_edges = 0; m_stby = 0; m_restrt = 1; m_wlreg = '0;
  endtask

  task automatic model_edge();
    bit rq, gj, sby_on;
    rq = bus.STRT1 | bus.STRT2 | bus.ALGA;
    gj = (m_low < 12);
`ifdef AGC_STANDBY_EN
    sby_on = bus.SBY;
`else
    sby_on = 0;
`endif
    m_edges++;
    if (rq) begin
      m_tp = 1; m_low = 0; m_restrt = 1; m_stby = 0;
    end else if (gj) begin
      m_tp = m_tp % 12 + 1; m_low++; m_restrt = 1; m_stby = 0;
    end else if (sby_on) begin
      m_stby = 1;
    end else begin
      m_stby = 0;
      if (m_tp == 8) begin
        m_wlreg = ~wl_n;
        if (wl_n[12] == 1'b0 && wl_n[13] == 1'b0) m_restrt = 0;
      end
      if (!(bus.MSTP && m_tp == 12)) m_tp = m_tp % 12 + 1;
    end
  endtask

  task automatic check_all();
    logic [11:0] got_t, exp_t;
    got_t = {bus.T12_n, bus.T11_n, bus.T10_n, bus.T09_n, bus.T08_n, bus.T07_n,
             bus.T06_n, bus.T05_n, bus.T04_n, bus.T03_n, bus.T02_n, bus.T01_n};
    exp_t = '1;
    if (!m_stby) exp_t[m_tp - 1] = 1'b0;
    check_val("tpulse", {20'd0, got_t}, {20'd0, exp_t});
    check_val("gojam", {31'd0, bus.GOJAM}, {31'd0, m_low < 12});
    check_val("restrt", {31'd0, bus.RESTRT}, {31'd0, m_restrt});
    check_val("wlreg", {16'd0, bus.WLREG}, {16'd0, m_wlreg});
    check_val("fs", {20'd0, bus.FS}, (m_edges / 12) % 4096);
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK);
      model_edge();
      @(negedge CLOCK);
      check_all();
    end
  endtask

  task automatic wait_gojam_low();
    int budget = 40;
    while (bus.GOJAM && budget > 0) begin cycle(1); budget--; end
    check_val("gojam_timeout", {31'd0, bus.GOJAM}, 32'd0);
  endtask

  initial begin
    SIM_RST_n = 1'b0;
    {bus.STRT1, bus.STRT2, bus.ALGA, bus.MSTP, bus.SBY} = '0;
    {bus.C24A, bus.C44P, bus.WL15, bus.WL16, bus.XT0_n, bus.YT0_n, bus.XB7_n,
     bus.YB0_n, bus.FETCH0, bus.INKL, bus.MONWBK, bus.SHIFT, bus.RADRZ} = '0;
    set_wl(16'hFFFF);
    model_reset();
    #25;
    check_all();
    check_val("rst_t01", {31'd0, bus.T01_n}, 32'd0);
    @(negedge CLOCK);
    SIM_RST_n = 1'b1;

    // Power-up sequence: GOJAM for 11 edges, clear on the 12th with FS=1.
    cycle(11);
    check_val("gojam_11", {31'd0, bus.GOJAM}, 32'd1);
    cycle(1);
    check_val("gojam_12", {31'd0, bus.GOJAM}, 32'd0);
    check_val("fs_12", {20'd0, bus.FS}, 32'd1);

    // Long STRT1 request holds T01.
    bus.STRT1 = 1'b1;
    cycle(20);
    check_val("strt_t01", {31'd0, bus.T01_n}, 32'd0);
    bus.STRT1 = 1'b0;
    cycle(11);
    check_val("post_rq_11", {31'd0, bus.GOJAM}, 32'd1);
    cycle(1);
    check_val("post_rq_12", {31'd0, bus.GOJAM}, 32'd0);

    // WL13/WL14 low at a TP=8 capture clears RESTRT.
    set_wl(16'hCFFF);
    cycle(12);
    check_val("wl_3000", {16'd0, bus.WLREG}, 32'h3000);
    check_val("restrt_clr", {31'd0, bus.RESTRT}, 32'd0);
    set_wl(16'h5A5A);

    // Short request re-sets RESTRT; WLREG frozen during GOJAM.
    bus.STRT1 = 1'b1;
    cycle(5);
    bus.STRT1 = 1'b0;
    check_val("restrt_set", {31'd0, bus.RESTRT}, 32'd1);
    cycle(11);
    check_val("wl_hold", {16'd0, bus.WLREG}, 32'h3000);
    wait_gojam_low();

    // Monitor stop parks at T12.
    bus.MSTP = 1'b1;
    cycle(30);
    check_val("mstp_t12", {31'd0, bus.T12_n}, 32'd0);
    bus.MSTP = 1'b0;
    cycle(1);
    check_val("mstp_t01", {31'd0, bus.T01_n}, 32'd0);

    // Standby (behaviour depends on build option; model follows the same macro).
    bus.SBY = 1'b1;
    cycle(30);
    bus.SBY = 1'b0;
    cycle(5);

    // Asynchronous reset mid-operation.
    #2 SIM_RST_n = 1'b0;
    #1 model_reset();
    check_all();
    #2 SIM_RST_n = 1'b1;
    cycle(14);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bus.STRT1 = ($urandom_range(0, 59) == 0);
      bus.STRT2 = ($urandom_range(0, 99) == 0);
      bus.ALGA  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) bus.MSTP = ~bus.MSTP;
      if ($urandom_range(0, 24) == 0) bus.SBY = ~bus.SBY;
      if ($urandom_range(0, 3) == 0) set_wl(16'(($urandom() & 32'hFFFF) & ~32'h3000));
      else set_wl(16'($urandom()));
      cycle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/agc_core.md
# agc_core

Central timing and restart core of the AGC logic simulation. It generates the 12-phase memory-cycle time pulses (T01–T12) from the master clock and sequences the GOJAM restart. It also maintains the RESTRT flag, captures the write-line bus once per memory cycle, and runs a free-running MCT scaler. The top-level simulation drives all AGC control inputs into this block.

## Interface
- Parameters: none.
- CLOCK  input  1  master clock, rising-edge active (1.024 MHz nominal).
- SIM_RST_n  input  1  asynchronous reset, active-low.
- STRT1, STRT2  input  1 each  restart requests, active-high.
- ALGA  input  1  alarm restart request, active-high.
- MSTP  input  1  monitor stop: hold the time-pulse sequence at T12.
- SBY  input  1  standby request (see Configuration).
- WL01_n … WL16_n  input  1 each  write-line bits 1–16, active-low.
- All remaining control inputs of the AGC port list are input, 1 bit each, and have no effect in this revision. This covers C24A…C44P, WL15/WL16 positive copies, XT*/YT*/XB7_n/YB0_n, FETCH*, INKL*, MON*, SHIFT*, RADR*, etc.
- T01_n … T12_n  output  1 each  one-hot time pulses, active-low.
- GOJAM  output  1  restart in progress.
- RESTRT  output  1  sticky restart-occurred flag.
- WLREG  output  16  captured write-line word, true polarity, bit 1 = WL01.
- FS  output  12  MCT scaler.

## Operation
- Restart request RQ = STRT1 | STRT2 | ALGA, sampled on rising CLOCK.
- Time-pulse state TP ∈ {1..12}; exactly one T*_n is low, except in standby.
- TP advances 1→2→…→12→1 by one step per clock.
- While RQ=1:
  - GOJAM=1.
  - TP is forced to 1 (held at T01).
  - RESTRT is set.
  - WLREG capture is suppressed.
- After RQ falls, GOJAM stays 1 while TP advances normally. GOJAM clears on the edge that moves TP from 12 to 1. That is the 12th edge sampling RQ=0, counting the first low sample.
- While GOJAM=1, RESTRT is held set.
- MSTP=1 with GOJAM=0: when TP reaches 12 it holds at 12 until MSTP=0. GOJAM overrides MSTP.
- WLREG capture: on a rising edge with TP=8 and GOJAM=0, WLREG <= ~{WL16_n … WL01_n}.
- RESTRT clear: on a capture edge where WL13_n=0 and WL14_n=0, RESTRT clears. The capture itself still occurs.
- Scaler:
  - A free-running mod-12 prescaler PS is independent of TP, MSTP and GOJAM.
  - FS increments when PS wraps 11→0.
  - FS wraps 4095→0.

## Timing
- Reset values (asynchronous, while SIM_RST_n=0): TP=1 (T01_n=0, others 1), GOJAM=1, RESTRT=1, WLREG=0, FS=0, PS=0.
- After reset release, GOJAM follows the same post-request rule as RQ falling.
  - First edge: TP 1→2.
  - 12th edge: TP returns to 1 and GOJAM becomes 0.
- All outputs are registered; a change is visible after the edge that causes it. No combinational input-to-output paths.
- RQ re-asserted mid-sequence: TP is forced to 1 on the next edge and the 12-edge count restarts.
- Reset mid-operation: immediate return to the reset values.
- FS first increments on the 12th edge after reset release.

## Configuration
- AGC_STANDBY_EN defined:
  - SBY=1 with GOJAM=0 freezes TP and drives all T*_n high.
  - SBY=1 also suppresses WLREG capture.
  - PS and FS keep counting.
  - When SBY returns to 0, TP resumes from its held value.
  - RQ overrides SBY.
- Not defined: SBY is ignored.

## Test plan
- Reset, release, 12 clocks -> T01..T12 sequence; GOJAM=1 through 11 edges, 0 on the 12th (TP=1); FS=1; RESTRT=1.
- STRT1 high 20 clocks -> TP held at T01, GOJAM=1; after release GOJAM drops exactly 12 edges later.
- WL13_n=0, WL14_n=0, others 1, with GOJAM=0 -> at the next TP=8 edge, WLREG=16'h3000 and RESTRT=0.
- STRT1 5-clock pulse after RESTRT cleared -> RESTRT=1 and GOJAM=1; WLREG unchanged during GOJAM.
- MSTP=1 -> TP holds at T12 (T12_n=0) while FS keeps counting; MSTP=0 -> next edge gives T01.
- With AGC_STANDBY_EN, SBY=1 -> all T*_n=1 and FS still increments every 12 clocks; without the macro, the sequence is unaffected.
